// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    // Width of the starvation counter; covers STARVE_MAX up to 15.
    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational arbitration: data wins unless fetch has been starved
// for STARVE_MAX consecutive data grants.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                if_req,
    input  logic                if_flush,
    input  logic                d_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_valid,
    output logic                owner
);

    logic starve_hit;

    assign starve_hit = if_req && (starve_cnt == STARVE_W'(STARVE_MAX));

    // Priority pick between the data and fetch requesters.
    always_comb begin
        grant_valid = 1'b0;
        owner       = OWN_I;
        if (d_req && !starve_hit) begin
            grant_valid = 1'b1;
            owner       = OWN_D;
        end else if (if_req && !if_flush) begin
            grant_valid = 1'b1;
            owner       = OWN_I;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data
// load/store; one outstanding transaction, all outputs registered.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    arb_state_t          state;
    arb_owner_t          owner;
    logic [STARVE_W-1:0] starve_cnt;
    logic                kill_flag;

    logic                grant_valid;
    logic                pick_owner;
    logic                fetch_flush;
    logic                kill_now;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .if_req      (if_req),
        .if_flush    (if_flush),
        .d_req       (d_req),
        .starve_cnt  (starve_cnt),
        .grant_valid (grant_valid),
        .owner       (pick_owner)
    );

    assign fetch_flush = (owner == OWN_I) && if_flush;
    // A flush arriving in the same cycle as rvalid must also suppress ready.
    assign kill_now    = kill_flag || fetch_flush;

    // Transaction FSM, starvation counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
            kill_flag  <= 1'b0;
            if_rdata   <= '0;
            if_ready   <= 1'b0;
            d_rdata    <= '0;
            d_ready    <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            busy       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;

            if (!if_req) begin
                starve_cnt <= '0;
            end else if (state == IDLE && grant_valid) begin
                if (pick_owner == OWN_I) begin
                    starve_cnt <= '0;
                end else if (!if_flush && starve_cnt != STARVE_W'(STARVE_MAX)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner   <= arb_owner_t'(pick_owner);
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                        if (pick_owner == OWN_D) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_be    <= d_be;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                        if (fetch_flush) begin
                            kill_flag <= 1'b1;
                        end
                    end else if (fetch_flush) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WAIT: begin
                    if (fetch_flush) begin
                        kill_flag <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        state <= RESP;
                        if (owner == OWN_D) begin
                            d_rdata <= mem_rdata;
                            d_ready <= !kill_now;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= !kill_now;
                        end
                    end
                end
                RESP: begin
                    kill_flag <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with requests already driven; ends in RESP.
    task automatic xact(input string tag, input logic [31:0] exp_addr, input logic exp_we,
                        input logic exp_d, input logic [31:0] rdata);
        step();
        check_val({tag, "_req"}, 32'(mem_req), 32'd1);
        check_val({tag, "_addr"}, mem_addr, exp_addr);
        check_val({tag, "_we"}, 32'(mem_we), 32'(exp_we));
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check_val({tag, "_req_drop"}, 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        step();
        mem_rvalid = 1'b0;
        check_val({tag, "_if_ready"}, 32'(if_ready), 32'(!exp_d));
        check_val({tag, "_d_ready"}, 32'(d_ready), 32'(exp_d));
        if (exp_d) check_val({tag, "_d_rdata"}, d_rdata, rdata);
        else       check_val({tag, "_if_rdata"}, if_rdata, rdata);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ready", 32'({if_ready, d_ready}), 32'd0);
        check_val("rst_mem_be", 32'(mem_be), 32'd0);
        rst = 1'b0;
        step();

        // Fetch only, minimum latency.
        if_req = 1'b1; if_addr = 32'h100;
        step();
        check_val("f_req", 32'(mem_req), 32'd1);
        check_val("f_addr", mem_addr, 32'h100);
        check_val("f_we", 32'(mem_we), 32'd0);
        check_val("f_be", 32'(mem_be), 32'hF);
        check_val("f_busy1", 32'(busy), 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check_val("f_req_drop", 32'(mem_req), 32'd0);
        check_val("f_busy2", 32'(busy), 32'd1);
        check_val("f_ready_early", 32'(if_ready), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        step();
        mem_rvalid = 1'b0;
        check_val("f_ready", 32'(if_ready), 32'd1);
        check_val("f_rdata", if_rdata, 32'h00500093);
        check_val("f_busy3", 32'(busy), 32'd1);
        if_req = 1'b0;
        step();
        check_val("f_ready_pulse", 32'(if_ready), 32'd0);
        check_val("f_busy_idle", 32'(busy), 32'd0);

        // Simultaneous fetch and store: data first, fetch right after.
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        step();
        check_val("s_addr", mem_addr, 32'h2000);
        check_val("s_we", 32'(mem_we), 32'd1);
        check_val("s_wdata", mem_wdata, 32'hDEADBEEF);
        check_val("s_be", 32'(mem_be), 32'h3);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0;
        step();
        mem_rvalid = 1'b0;
        check_val("s_d_ready", 32'(d_ready), 32'd1);
        check_val("s_if_ready", 32'(if_ready), 32'd0);
        d_req = 1'b0;
        step();
        check_val("s_idle_busy", 32'(busy), 32'd0);
        xact("s_fetch", 32'h104, 1'b0, 1'b0, 32'h00000013);
        if_req = 1'b0;
        step();

        // Starvation: four data grants, then one fetch, then data resumes.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'h55; d_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            xact("st_d", 32'h3000 + 32'(i) * 4, 1'b1, 1'b1, 32'h0);
            d_addr = d_addr + 32'd4;
            step();
        end
        xact("st_i", 32'h200, 1'b0, 1'b0, 32'h00A00113);
        if_req = 1'b0;
        step();
        xact("st_resume", 32'h3010, 1'b1, 1'b1, 32'h0);
        check_val("st_cnt_zero", 32'(dut.starve_cnt), 32'd0);
        d_req = 1'b0;
        step();

        // Flush in ISSUE while gnt held low.
        if_req = 1'b1; if_addr = 32'h300;
        step();
        check_val("fi_req", 32'(mem_req), 32'd1);
        step();
        if_flush = 1'b1;
        step();
        if_flush = 1'b0; if_req = 1'b0;
        check_val("fi_req_drop", 32'(mem_req), 32'd0);
        check_val("fi_busy", 32'(busy), 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check_val("fi_stray_gnt", 32'({mem_req, busy}), 32'd0);
        step();
        check_val("fi_no_ready", 32'(if_ready), 32'd0);

        // Flush in WAIT: response consumed, ready suppressed.
        if_req = 1'b1; if_addr = 32'h304;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        if_flush = 1'b1;
        step();
        if_flush = 1'b0; if_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        step();
        mem_rvalid = 1'b0;
        check_val("fw_no_ready", 32'(if_ready), 32'd0);
        check_val("fw_busy_resp", 32'(busy), 32'd1);
        step();
        check_val("fw_idle", 32'({busy, if_ready}), 32'd0);

        // Stalled memory: fields stable, rvalid in ISSUE ignored.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_wdata = 32'h11; d_be = 4'hF;
        step();
        for (int i = 0; i < 5; i++) begin
            check_val("sm_req", 32'(mem_req), 32'd1);
            check_val("sm_fields", {mem_addr[27:0], mem_be}, {28'h0004000, 4'hF});
            check_val("sm_wdata", mem_wdata, 32'h11);
            mem_rvalid = (i == 2);
            step();
        end
        mem_rvalid = 1'b0;
        check_val("sm_no_early_ready", 32'(d_ready), 32'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check_val("sm_wait_ready", 32'(d_ready), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_rvalid = 1'b0;
        check_val("sm_d_ready", 32'(d_ready), 32'd1);
        check_val("sm_d_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 1'b0;
        step();

        // Reset in WAIT, then a stray rvalid.
        if_req = 1'b1; if_addr = 32'h400;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst = 1'b1;
        step();
        check_val("rw_ctrl", 32'({mem_req, mem_we, busy, if_ready, d_ready}), 32'd0);
        check_val("rw_addr", mem_addr, 32'd0);
        check_val("rw_if_rdata", if_rdata, 32'd0);
        check_val("rw_d_rdata", d_rdata, 32'd0);
        rst = 1'b0; if_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
        step();
        mem_rvalid = 1'b0;
        step();
        check_val("rw_stray", 32'({if_ready, d_ready, busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Holds at most one outstanding memory transaction.
- Data requests have priority; a starvation counter guarantees forward progress for fetch.
- Drives the core's instr_ready and presents a req/gnt/rvalid handshake to the memory.
- Sits between the pipeline unit and the memory/bus model.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
STARVE_MAX, 4, consecutive data grants allowed while fetch waits (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held stable until if_ready or if_flush
if_addr  in  ADDR_W  fetch address (pc)
if_flush  in  1  pipeline redirect; kills any pending or in-flight fetch
if_rdata  out  DATA_W  fetched instruction, valid while if_ready
if_ready  out  1  one-cycle pulse, fetch complete
d_req  in  1  data request, held stable until d_ready
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  byte enables
d_rdata  out  DATA_W  load data, valid while d_ready
d_ready  out  1  one-cycle pulse, data access complete
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  response valid (also for writes), at least 1 cycle after gnt
mem_rdata  in  DATA_W  read data
busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE, owner=I, starve_cnt=0, kill_flag=0. All outputs 0, including rdata registers.
- Reset has priority over everything. Reset mid-transaction abandons it; a later mem_rvalid/mem_gnt is ignored in IDLE.
- All outputs are registered.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: arbitrate on the sampled requests.
  - d_req && !(if_req && starve_cnt==STARVE_MAX) -> owner=D.
  - Else if_req && !if_flush -> owner=I.
  - On a grant, latch the owner's we/addr/wdata/be into the mem_* registers (fetch: we=0, be=all ones), set mem_req=1, go to ISSUE.
- ISSUE: mem_req held with stable fields until mem_gnt. On mem_gnt: mem_req=0 next cycle, go to WAIT. mem_rvalid is ignored in ISSUE.
- ISSUE with owner=I and if_flush before mem_gnt:
  - If mem_gnt is low that cycle: drop mem_req, return to IDLE with no if_ready.
  - If mem_gnt is high the same cycle: go to WAIT with kill_flag=1.
- WAIT: on mem_rvalid, capture mem_rdata into if_rdata or d_rdata and go to RESP. if_flush during WAIT (owner=I) sets kill_flag.
- RESP: pulse the owner's ready for exactly one cycle (suppressed if kill_flag), clear kill_flag, go to IDLE.
  - The requester must update or drop its request by the next edge. IDLE samples the new value, so there is no double grant.
- Minimum latency: req sampled at cycle t; mem_req at t+1; gnt at t+1; rvalid at t+2; ready at t+3. Back-to-back accesses: one every 4 cycles minimum.
- starve_cnt:
  - Increments on a D grant while if_req && !if_flush, saturating at STARVE_MAX.
  - Clears on an I grant or when if_req==0.
- At most one of if_ready/d_ready is high in any cycle.
- mem_gnt while mem_req==0 is ignored.

Decomposition:
- Add to defs.svh: arb_state_t enum (IDLE, ISSUE, WAIT, RESP) and arb_owner_t enum (OWN_I, OWN_D).
- One combinational sub-module, mem_arb_pick: inputs if_req, if_flush, d_req, starve_cnt; outputs grant_valid and owner. It is unit-testable in isolation.

Test Plan:
- Fetch only: if_addr=0x100, memory returns 0x00500093 one cycle after gnt -> mem_addr=0x100, mem_we=0, mem_be=4'hF; if_rdata=0x00500093 with if_ready at t+3; busy high for 3 cycles.
- Simultaneous if_req and d_req (store, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011) -> data served first with mem_we=1 and matching fields; fetch issues in the IDLE cycle after d_ready.
- Starvation: d_req held continuously with fresh stores, if_req waiting, STARVE_MAX=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes; starve_cnt returns to 0.
- Flush in ISSUE with mem_gnt held low 3 cycles, if_flush at cycle 2 -> mem_req drops, no if_ready, state returns to IDLE. Flush in WAIT -> rvalid consumed, if_ready stays 0.
- Stalled memory: mem_gnt delayed 5 cycles -> mem_req and all mem_* fields stable throughout; rvalid asserted during ISSUE is ignored.
- rst=1 asserted in WAIT -> next cycle all outputs 0 and state IDLE; a subsequent stray mem_rvalid produces no ready pulse.
